// File: rtl/mmio_pkg.sv
// mmio_pkg: shared definitions for the memory-mapped UART transmitter.
//  - Register word offsets (address[3:2]) inside the 16-byte window.
//  - STATUS register bit positions.
//  - Transmit FSM state type.
//  - div_sanitize(): a divider of 0 is stored as 1 so a bit always lasts >= 1 cycle.
package mmio_pkg;

  // Word offsets, i.e. the value of address[3:2] for each register.
  localparam logic [1:0] UART_TXDATA = 2'd0;  // byte offset 0x0
  localparam logic [1:0] UART_STATUS = 2'd1;  // byte offset 0x4
  localparam logic [1:0] UART_DIV    = 2'd2;  // byte offset 0x8
  localparam logic [1:0] UART_CTRL   = 2'd3;  // byte offset 0xC

  // STATUS bit positions; fifo count occupies [STAT_CNT_LSB +: 4].
  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  function automatic logic [15:0] div_sanitize(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: CPU data-memory port as seen by the UART window.
//  memory_address/memory_write/memory_byte_enable/memory_we : CPU -> UART
//  sel/rdata                                                 : UART -> read mux
//  dbg_state                                                 : UART FSM state, observation only
// Handshake: there is no ready/backpressure. A store is a single-cycle strobe;
// it is taken on the rising clk edge where memory_we=1 and sel=1. sel and rdata
// are combinational from memory_address, so a read completes in the same cycle.
interface mmio_uart_tx_if
  import mmio_pkg::*;
  ();
  logic [31:0] memory_address;
  logic [31:0] memory_write;
  logic [3:0]  memory_byte_enable;
  logic        memory_we;
  logic        sel;
  logic [31:0] rdata;
  uart_state_t dbg_state;

  modport master (
    output memory_address, memory_write, memory_byte_enable, memory_we,
    input  sel, rdata, dbg_state
  );

  modport slave (
    input  memory_address, memory_write, memory_byte_enable, memory_we,
    output sel, rdata, dbg_state
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, no lookahead, no overflow tracking.
//  i_push/i_wdata : write request; dropped when full unless i_pop is also set
//  i_pop          : read request; ignored when empty (even with a same-cycle push)
//  o_rdata        : current head entry (valid when !o_empty)
//  o_full/o_empty : flags; o_count : occupancy, $clog2(DEPTH)+1 bits
// DEPTH must be a power of two >= 2 so pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter sitting beside the data RAM.
// Ports:
//  clk, rst_n : clock (rising edge), asynchronous active-low reset
//  bus        : mmio_uart_tx_if.slave -- CPU store port in, sel/rdata/dbg_state out
//  tx         : serial output, idle high
//  irq        : only when MMIO_UART_IRQ_EN is defined; irq_en & empty & !busy, registered
// Register map (address[3:2]):
//  0x0 TXDATA W: push write[7:0] when byte_enable[0]; R: 0
//  0x4 STATUS R: [0]full [1]empty [2]busy [3]overflow [7:4]count; W: bit3=1 clears overflow
//  0x8 DIV    R/W [15:0], written only with byte_enable[1:0]=11; 0 is stored as 1
//  0xC CTRL   [0]irq_en with MMIO_UART_IRQ_EN, otherwise reads 0 and ignores writes
// Optional feature macro: MMIO_UART_IRQ_EN.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic            clk,
  input  logic            rst_n,
  mmio_uart_tx_if.slave   bus,
  output logic            tx
`ifdef MMIO_UART_IRQ_EN
  ,
  output logic            irq
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Bus decode
  logic        w_sel;
  logic        w_wr;
  logic [1:0]  w_off;
  logic        w_push_req;
  logic [31:0] w_rdata;

  // FIFO
  logic          w_pop;
  logic [7:0]    w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;

  // Registers
  logic [15:0] r_div;
  logic        r_overflow;
  logic        w_ctrl_irq_en;

  // Transmit FSM and datapath
  uart_state_t r_state;
  uart_state_t w_state_nxt;
  logic [7:0]  r_shift;
  logic [15:0] r_bit_div;
  logic [15:0] r_baud;
  logic [2:0]  r_bit_idx;
  logic        w_bit_end;
  logic        w_busy;

  logic        w_unused;
  assign w_unused = &{1'b0, bus.memory_address[1:0], bus.memory_write[31:16],
                      bus.memory_byte_enable[3:2]};

  assign w_sel      = (bus.memory_address[31:4] == BASE_ADDR[31:4]);
  assign w_wr       = w_sel && bus.memory_we;
  assign w_off      = bus.memory_address[3:2];
  assign w_push_req = w_wr && (w_off == UART_TXDATA) && bus.memory_byte_enable[0];
  assign bus.sel       = w_sel;
  assign bus.dbg_state = r_state;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push_req),
    .i_wdata (bus.memory_write[7:0]),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div      <= div_sanitize(DEFAULT_DIV);
      r_overflow <= 1'b0;
    end else begin
      if (w_wr && (w_off == UART_DIV) && (bus.memory_byte_enable[1:0] == 2'b11))
        r_div <= div_sanitize(bus.memory_write[15:0]);
      // A push that the FIFO cannot take (full and no pop this edge) is lost.
      if (w_push_req && w_full && !w_pop)
        r_overflow <= 1'b1;
      else if (w_wr && (w_off == UART_STATUS) && bus.memory_byte_enable[0] &&
               bus.memory_write[STAT_OVF])
        r_overflow <= 1'b0;
    end
  end

`ifdef MMIO_UART_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && (w_off == UART_CTRL) && bus.memory_byte_enable[0])
        r_irq_en <= bus.memory_write[0];
      r_irq <= r_irq_en && w_empty && !w_busy;
    end
  end

  assign irq           = r_irq;
  assign w_ctrl_irq_en = r_irq_en;
`else
  assign w_ctrl_irq_en = 1'b0;
`endif

  // --------------------------------------------------------------- read mux
  always_comb begin
    w_rdata = '0;
    if (w_sel) begin
      case (w_off)
        UART_STATUS: begin
          w_rdata[STAT_FULL]              = w_full;
          w_rdata[STAT_EMPTY]             = w_empty;
          w_rdata[STAT_BUSY]              = w_busy;
          w_rdata[STAT_OVF]               = r_overflow;
          w_rdata[STAT_CNT_LSB +: 4]      = 4'(w_count);
        end
        UART_DIV:  w_rdata[15:0] = r_div;
        UART_CTRL: w_rdata[0]    = w_ctrl_irq_en;
        default:   w_rdata       = '0;
      endcase
    end
  end
  assign bus.rdata = w_rdata;

  // ------------------------------------------------------------ transmit FSM
  assign w_busy    = (r_state != IDLE);
  assign w_bit_end = (r_baud == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // The last STOP cycle pops the next byte straight into START, so queued
  // frames go out with no idle cycle between them.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_bit_end) w_state_nxt = DATA;
      end
      DATA: begin
        if (w_bit_end && (r_bit_idx == 3'd7)) w_state_nxt = STOP;
      end
      STOP: begin
        if (w_bit_end) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath. bit_div is captured at each frame start so DIV writes during a
  // frame only affect the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bit_div <= 16'd1;
      r_baud    <= '0;
      r_bit_idx <= '0;
    end else if (w_pop) begin
      r_shift   <= w_head;
      r_bit_div <= r_div;
      r_baud    <= r_div - 16'd1;
      r_bit_idx <= '0;
    end else if (r_state != IDLE) begin
      if (w_bit_end) begin
        r_baud <= r_bit_div - 16'd1;
        if (r_state == DATA) begin
          r_shift   <= {1'b0, r_shift[7:1]};
          r_bit_idx <= r_bit_idx + 3'd1;
        end
      end else begin
        r_baud <= r_baud - 16'd1;
      end
    end
  end

  // tx is decoded from flops only; with the async state reset it goes high
  // as soon as rst_n falls.
  always_comb begin
    tx = 1'b1;
    case (r_state)
      START:   tx = 1'b0;
      DATA:    tx = r_shift[0];
      default: tx = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: self-checking bench for mmio_uart_tx.
// A serial receiver samples tx at mid-bit and compares each byte with exp_q;
// cycle-level tx/busy expectations come from a frame-slot reference function.
module tb_mmio_uart_tx;
  import mmio_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_2000;
  localparam int          DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx;
`ifdef MMIO_UART_IRQ_EN
  logic irq;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] stream_buf[16];
  logic [7:0] burst_buf[16];
  int mon_div = 16;
  int mon_t = -1;
  logic [7:0] mon_byte;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (DEPTH),
    .DEFAULT_DIV (16'd16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .tx    (tx)
`ifdef MMIO_UART_IRQ_EN
    ,
    .irq   (irq)
`endif
  );

  // ------------------------------------------------------ clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------ serial receiver
  initial begin
    int rel;
    int bidx;
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        mon_t = -1;
      end else if (mon_t < 0) begin
        if (tx === 1'b0) begin
          mon_t    = 0;
          mon_byte = '0;
        end
      end else begin
        mon_t++;
        rel = mon_t - mon_div / 2;
        if (rel > 0 && (rel % mon_div) == 0) begin
          bidx = rel / mon_div;
          if (bidx <= 8) begin
            mon_byte[bidx-1] = tx;
          end else begin
            n_cmp++;
            if (tx !== 1'b1) begin
              n_err++;
              $display("FAIL stop_bit: tx=%b expected 1", tx);
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
              n_err++;
              $display("FAIL rx_byte: got %02h, expected no byte", mon_byte);
            end else begin
              exp_b = exp_q.pop_front();
              if (mon_byte !== exp_b) begin
                n_err++;
                $display("FAIL rx_byte: got %02h expected %02h", mon_byte, exp_b);
              end
            end
            mon_t = -1;
          end
        end
      end
    end
  end

  // ------------------------------------------------------ reference model
  function automatic logic [31:0] reg_addr(input logic [1:0] off);
    return BASE + {28'd0, off, 2'b00};
  endfunction

  function automatic logic [31:0] status_word(input bit full, input bit empty,
                                               input bit busy, input bit ovf,
                                               input int cnt);
    return 32'(cnt % 16) * 16 + (ovf ? 8 : 0) + (busy ? 4 : 0) + (empty ? 2 : 0) + (full ? 1 : 0);
  endfunction

  // Line level k cycles after the first push edge, for n frames sent gap-free
  // from stream_buf with d cycles per bit: slot 0 start, 1..8 data LSB first, 9 stop.
  function automatic logic ref_tx(input int k, input int d, input int n);
    int f;
    int s;
    logic [7:0] b;
    if (k < 1) return 1'b1;
    f = (k - 1) / (10 * d);
    if (f >= n) return 1'b1;
    s = ((k - 1) % (10 * d)) / d;
    b = stream_buf[f];
    if (s == 0) return 1'b0;
    if (s <= 8) return b[s-1];
    return 1'b1;
  endfunction

  // ------------------------------------------------------ driver tasks
  task automatic bus_idle();
    bus.memory_we          = 1'b0;
    bus.memory_byte_enable = 4'h0;
    bus.memory_write       = 32'h0;
    bus.memory_address     = BASE + 32'h100;
  endtask

  task automatic write_addr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    bus.memory_address     = a;
    bus.memory_write       = d;
    bus.memory_byte_enable = be;
    bus.memory_we          = 1'b1;
    @(negedge clk);
    bus.memory_we          = 1'b0;
    bus.memory_byte_enable = 4'h0;
  endtask

  task automatic write_reg(input logic [1:0] off, input logic [31:0] d, input logic [3:0] be);
    write_addr(reg_addr(off), d, be);
  endtask

  task automatic read_reg(input logic [1:0] off, output logic [31:0] d);
    @(negedge clk);
    bus.memory_address = reg_addr(off);
    #1;
    d = bus.rdata;
  endtask

  // Pushes burst_buf[0..n-1] on n consecutive clock edges.
  task automatic push_burst(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.memory_address     = reg_addr(UART_TXDATA);
      bus.memory_write       = {24'd0, burst_buf[i]};
      bus.memory_byte_enable = 4'h1;
      bus.memory_we          = 1'b1;
    end
    @(negedge clk);
    bus.memory_we          = 1'b0;
    bus.memory_byte_enable = 4'h0;
  endtask

  task automatic check_stream(input int d, input int n, input int k0);
    logic exp_busy;
    bus.memory_address = reg_addr(UART_STATUS);
    for (int k = k0; k <= 10 * d * n + 2; k++) begin
      if (k != k0) @(negedge clk);
      #1;
      exp_busy = (k >= 1) && (k <= 10 * d * n);
      n_cmp++;
      if (tx !== ref_tx(k, d, n)) begin
        n_err++;
        $display("FAIL stream_tx k=%0d: tx=%b expected %b", k, tx, ref_tx(k, d, n));
      end
      n_cmp++;
      if (bus.rdata[STAT_BUSY] !== exp_busy) begin
        n_err++;
        $display("FAIL stream_busy k=%0d: busy=%b expected %b", k, bus.rdata[STAT_BUSY], exp_busy);
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    bus.memory_address = reg_addr(UART_STATUS);
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #1;
      if (bus.rdata[2:0] == 3'b010) done = 1'b1;
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL wait_idle: status=%08h not idle after %0d cycles", bus.rdata, budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reg(input string name, input logic [1:0] off, input logic [31:0] exp);
    logic [31:0] d;
    read_reg(off, d);
    n_cmp++;
    if (d !== exp) begin
      n_err++;
      $display("FAIL %s: read %08h expected %08h", name, d, exp);
    end
  endtask

  // ------------------------------------------------------ tests
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (tx !== 1'b1) begin
      n_err++;
      $display("FAIL reset_tx: tx=%b expected 1", tx);
    end
    rst_n = 1'b1;
    check_reg("reset_status", UART_STATUS, status_word(0, 1, 0, 0, 0));
    check_reg("reset_div", UART_DIV, 32'd16);
    check_reg("reset_txdata_read", UART_TXDATA, 32'd0);
    check_reg("reset_ctrl", UART_CTRL, 32'd0);
    n_cmp++;
    if (bus.dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL reset_state: state=%0d expected %0d", bus.dbg_state, IDLE);
    end
`ifdef MMIO_UART_IRQ_EN
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL reset_irq: irq=%b expected 0", irq);
    end
`endif
    bus.memory_address = BASE + 32'h10;
    #1;
    n_cmp++;
    if (bus.sel !== 1'b0 || bus.rdata !== 32'd0) begin
      n_err++;
      $display("FAIL out_of_window_read: sel=%b rdata=%08h expected 0/0", bus.sel, bus.rdata);
    end
  endtask

  task automatic test_regs();
    write_reg(UART_DIV, 32'd0, 4'hF);
    check_reg("div_zero_as_one", UART_DIV, 32'd1);
    write_reg(UART_DIV, 32'd7, 4'h1);
    check_reg("div_partial_be", UART_DIV, 32'd1);
    write_addr(BASE + 32'h18, 32'd9, 4'hF);
    check_reg("div_outside_window", UART_DIV, 32'd1);
    write_reg(UART_DIV, 32'hABCD_0005, 4'h3);
    check_reg("div_write", UART_DIV, 32'd5);
    write_reg(UART_TXDATA, 32'h41, 4'hE);
    repeat (3) @(negedge clk);
    check_reg("txdata_be0_ignored", UART_STATUS, status_word(0, 1, 0, 0, 0));
    n_cmp++;
    if (tx !== 1'b1) begin
      n_err++;
      $display("FAIL txdata_be0_tx: tx=%b expected 1", tx);
    end
  endtask

  task automatic test_frame();
    write_reg(UART_DIV, 32'd4, 4'hF);
    mon_div = 4;
    stream_buf[0] = 8'h55;
    exp_q.push_back(8'h55);
    write_reg(UART_TXDATA, 32'h55, 4'h1);
    check_stream(4, 1, 0);
    wait_idle(50);
  endtask

  task automatic test_overflow();
    int n;
    int acc;
    n = DEPTH + 2;
    acc = (n < DEPTH + 1) ? n : DEPTH + 1;
    write_reg(UART_DIV, 32'd2, 4'hF);
    mon_div = 2;
    for (int i = 0; i < n; i++) begin
      burst_buf[i] = 8'($urandom);
      if (i < acc) exp_q.push_back(burst_buf[i]);
    end
    push_burst(n);
    bus.memory_address = reg_addr(UART_STATUS);
    #1;
    n_cmp++;
    if (bus.rdata !== status_word(acc - 1 == DEPTH, acc == 1, 1, n > acc, acc - 1)) begin
      n_err++;
      $display("FAIL overflow_status: read %08h expected %08h", bus.rdata,
               status_word(acc - 1 == DEPTH, acc == 1, 1, n > acc, acc - 1));
    end
    write_reg(UART_STATUS, 32'h8, 4'h1);
    check_reg("overflow_clear", UART_STATUS,
              status_word(acc - 1 == DEPTH, acc == 1, 1, 0, acc - 1));
    wait_idle(600);
    check_reg("overflow_drained", UART_STATUS, status_word(0, 1, 0, 0, 0));
  endtask

  task automatic test_back_to_back();
    int d;
    d = $urandom_range(1, 3);
    write_reg(UART_DIV, d, 4'hF);
    mon_div = d;
    burst_buf[0] = 8'hA5;
    burst_buf[1] = 8'h3C;
    stream_buf[0] = 8'hA5;
    stream_buf[1] = 8'h3C;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    push_burst(2);
    check_stream(d, 2, 1);
    wait_idle(100);
  endtask

  task automatic test_reset_mid();
    write_reg(UART_DIV, 32'd4, 4'hF);
    mon_div = 4;
    burst_buf[0] = 8'($urandom) & 8'hF7;
    burst_buf[1] = 8'($urandom);
    burst_buf[2] = 8'($urandom);
    stream_buf[0] = burst_buf[0];
    push_burst(3);
    repeat (16) @(negedge clk);
    #1;
    n_cmp++;
    if (tx !== ref_tx(18, 4, 1)) begin
      n_err++;
      $display("FAIL mid_data_bit3: tx=%b expected %b", tx, ref_tx(18, 4, 1));
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (tx !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset_tx: tx=%b expected 1", tx);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_div = 16;
    check_reg("post_reset_status", UART_STATUS, status_word(0, 1, 0, 0, 0));
    repeat (5) @(negedge clk);
    #1;
    n_cmp++;
    if (tx !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_tx: tx=%b expected 1", tx);
    end
    check_reg("post_reset_div", UART_DIV, 32'd16);
  endtask

  task automatic test_random();
    int d;
    int n;
    logic [7:0] b;
    logic [3:0] be;
    for (int it = 0; it < 6; it++) begin
      d = $urandom_range(1, 4);
      write_reg(UART_DIV, d, 4'hF);
      mon_div = d;
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        b  = 8'($urandom);
        be = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 4) == 0) begin
          write_addr(BASE + 32'h20, {24'd0, b}, 4'h1);
        end else begin
          write_reg(UART_TXDATA, {24'd0, b}, be);
          if (be[0]) exp_q.push_back(b);
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle(400);
      check_reg("random_idle_status", UART_STATUS, status_word(0, 1, 0, 0, 0));
    end
  endtask

`ifdef MMIO_UART_IRQ_EN
  task automatic test_irq();
    int d;
    logic exp_irq;
    d = 2;
    write_reg(UART_DIV, d, 4'hF);
    mon_div = d;
    write_reg(UART_CTRL, 32'd1, 4'h1);
    check_reg("ctrl_readback", UART_CTRL, 32'd1);
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL irq_enable: irq=%b expected 1", irq);
    end
    stream_buf[0] = 8'($urandom);
    exp_q.push_back(stream_buf[0]);
    write_reg(UART_TXDATA, {24'd0, stream_buf[0]}, 4'h1);
    for (int k = 0; k <= 10 * d + 4; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      exp_irq = (k == 0) || (k >= 10 * d + 2);
      n_cmp++;
      if (irq !== exp_irq) begin
        n_err++;
        $display("FAIL irq_frame k=%0d: irq=%b expected %b", k, irq, exp_irq);
      end
    end
    write_reg(UART_CTRL, 32'd0, 4'h1);
    @(negedge clk);
    #1;
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_disable: irq=%b expected 0", irq);
    end
    check_reg("ctrl_cleared", UART_CTRL, 32'd0);
  endtask
`else
  task automatic test_ctrl_disabled();
    write_reg(UART_CTRL, 32'd1, 4'hF);
    check_reg("ctrl_disabled", UART_CTRL, 32'd0);
  endtask
`endif

  // ------------------------------------------------------ sequence + report
  initial begin
    bus_idle();
    test_reset();
    test_regs();
    test_frame();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef MMIO_UART_IRQ_EN
    test_irq();
`else
    test_ctrl_disabled();
`endif
    wait_idle(200);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover_bytes: %0d bytes never received, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
